// File: rtl/timer_dev.sv
// Countdown timer on the processor bridge bus: CTRL/PRESET/COUNT registers,
// single-cycle reads and writes, IRQ on expiry (one-shot or auto-reload).
//
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   Sel, We      device select and write strobe from the bridge
//   Addr         word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   WD, RD       write data in, combinational read data out (0 when Sel=0)
//   IRQ          interrupt request = irq_flag & CTRL.IM
module timer_dev #(
    parameter int unsigned CNT_W    = 32,
    parameter logic [3:0]  CTRL_RST = 4'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Sel,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       ctrl, ctrl_nx;
    logic [CNT_W-1:0] preset, preset_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             irq_flag, irq_flag_nx;

    logic wr_ctrl;
    logic wr_preset;
    logic auto_rl;
    logic expire;
    logic en_clr;

    assign wr_ctrl   = Sel & We & (Addr == 2'd0);
    assign wr_preset = Sel & We & (Addr == 2'd1);
    // Modes 2 and 3 fall back to one-shot.
    assign auto_rl   = (ctrl[2:1] == 2'b01);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            ctrl     <= CTRL_RST;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_nx;
            ctrl     <= ctrl_nx;
            preset   <= preset_nx;
            count    <= count_nx;
            irq_flag <= irq_flag_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        expire   = 1'b0;
        en_clr   = 1'b0;

        unique case (state)
            IDLE: begin
                if (ctrl[0])
                    state_nx = LOAD;
            end
            LOAD: begin
                count_nx = preset;
                state_nx = CNT;
            end
            CNT: begin
                if (!ctrl[0]) begin
                    state_nx = IDLE;
                end else if (count > CNT_W'(1)) begin
                    count_nx = count - CNT_W'(1);
                end else begin
                    // PRESET=0 lands here too, so it expires like PRESET=1.
                    count_nx = '0;
                    state_nx = INT;
                end
            end
            INT: begin
                expire = 1'b1;
                if (auto_rl) begin
                    state_nx = LOAD;
                end else begin
                    en_clr   = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase

        // A CPU write clearing En stops the timer at once, freezing COUNT.
        if (wr_ctrl && !WD[0]) begin
            state_nx = IDLE;
            count_nx = count;
        end
    end

    always_comb begin
        ctrl_nx = ctrl;
        if (wr_ctrl)
            ctrl_nx = WD[3:0];
        else if (en_clr)
            ctrl_nx = ctrl & 4'b1110;
    end

    always_comb begin
        preset_nx = preset;
        if (wr_preset)
            preset_nx = WD[CNT_W-1:0];
    end

    // Register writes take priority over a same-cycle expiry.
    always_comb begin
        irq_flag_nx = irq_flag;
        if (wr_ctrl || wr_preset)
            irq_flag_nx = 1'b0;
        else if (expire)
            irq_flag_nx = 1'b1;
        else if (auto_rl)
            irq_flag_nx = 1'b0;
    end

    always_comb begin
        RD = '0;
        if (Sel) begin
            case (Addr)
                2'd0:    RD = 32'(ctrl);
                2'd1:    RD = 32'(preset);
                2'd2:    RD = 32'(count);
                default: RD = '0;
            endcase
        end
    end

    assign IRQ = irq_flag & ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: directed and random bus traffic scored against
// a cycle-level reference model of the timer.
module tb_timer_dev;

    localparam logic [3:0] CTRL_RST = 4'h0;

    logic        Clk;
    logic        Reset;
    logic        Sel;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    timer_dev #(.CNT_W(32), .CTRL_RST(CTRL_RST)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Sel   (Sel),
        .Addr  (Addr),
        .We    (We),
        .WD    (WD),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic [1:0]  a;
        logic        sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a run is tracked by its age in cycles since LOAD.
    // Age 0 = loading, ages 1..E count down, age E+1 = expiry cycle,
    // where E = max(loaded preset, 1).
    logic [3:0]  m_ctrl;
    logic [31:0] m_pre;
    logic [31:0] m_cnt;
    logic [31:0] m_load;
    logic        m_flag;
    bit          m_busy;
    int          m_age;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void reset_model();
        m_ctrl = CTRL_RST;
        m_pre  = '0;
        m_cnt  = '0;
        m_load = '0;
        m_flag = 1'b0;
        m_busy = 1'b0;
        m_age  = 0;
    endfunction

    function automatic int m_span();
        return (m_load == 0) ? 1 : int'(m_load);
    endfunction

    function automatic logic [31:0] exp_rd(bit sel, bit [1:0] a);
        if (!sel) return '0;
        case (a)
            2'd0:    return {28'b0, m_ctrl};
            2'd1:    return m_pre;
            2'd2:    return m_cnt;
            default: return '0;
        endcase
    endfunction

    function automatic void model_edge(bit sel, bit we, bit [1:0] a,
                                       logic [31:0] wd);
        bit          wc     = sel && we && (a == 2'd0);
        bit          wp     = sel && we && (a == 2'd1);
        bit          auto_m = (m_ctrl[2:1] == 2'b01);
        bit          set_f  = 1'b0;
        logic [31:0] c0     = m_cnt;
        int          e      = m_span();
        if (!m_busy) begin
            if (m_ctrl[0]) begin
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else if (m_age == 0) begin
            m_load = m_pre;
            m_cnt  = m_pre;
            m_age  = 1;
        end else if (m_age <= e) begin
            if (!m_ctrl[0]) begin
                m_busy = 1'b0;
            end else begin
                m_age++;
                m_cnt = (m_age <= e) ? m_load - 32'(m_age - 1) : 32'd0;
            end
        end else begin
            set_f = 1'b1;
            if (auto_m) begin
                m_age = 0;
            end else begin
                m_busy    = 1'b0;
                m_ctrl[0] = 1'b0;
            end
        end
        if (wc) begin
            m_ctrl = wd[3:0];
            if (!wd[0]) begin
                m_busy = 1'b0;
                m_cnt  = c0;
            end
        end
        if (wp) m_pre = wd;
        if (wc || wp)   m_flag = 1'b0;
        else if (set_f) m_flag = 1'b1;
        else if (auto_m) m_flag = 1'b0;
    endfunction

    task automatic cyc(bit sel, bit we, bit [1:0] a, logic [31:0] wd);
        exp_t x;
        @(posedge Clk);
        #1;
        Sel  = sel;
        We   = we;
        Addr = a;
        WD   = wd;
        x.rd  = exp_rd(sel, a);
        x.irq = m_flag & m_ctrl[3];
        x.a   = a;
        x.sel = sel;
        exp_q.push_back(x);
        model_edge(sel, we, a, wd);
    endtask

    task automatic reset_check(string tag);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        Sel   = 1'b1;
        We    = 1'b0;
        Addr  = 2'd2;
        #1;
        check({tag, "_count"}, RD, 32'd0);
        Addr = 2'd0;
        #1;
        check({tag, "_ctrl"}, RD, {28'b0, CTRL_RST});
        check({tag, "_irq"}, {31'b0, IRQ}, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        reset_model();
    endtask

    // Monitor: whatever the DUT presents mid-cycle is set against the
    // oldest pending expectation.
    always @(negedge Clk) begin
        if (!Reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("rd_sel%0d_a%0d", mon_e.sel, mon_e.a),
                  RD, mon_e.rd);
            check("irq", {31'b0, IRQ}, {31'b0, mon_e.irq});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit [1:0] ra;
        bit rs, rw;
        logic [31:0] rwd;

        Reset = 1'b1;
        Sel   = 1'b0;
        We    = 1'b0;
        Addr  = 2'd0;
        WD    = '0;
        reset_model();
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        // Reset values
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 2, 0);
        cyc(0, 0, 0, 0);

        // Bus rules
        cyc(1, 1, 2, 32'h1234);
        cyc(1, 0, 2, 0);
        cyc(1, 1, 3, 32'hDEAD_BEEF);
        cyc(1, 0, 3, 0);
        cyc(0, 1, 1, 32'h55);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 32'hFFFF_FFFF);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 0, 2, 0);

        // One-shot expiry
        cyc(1, 1, 1, 5);
        cyc(1, 1, 0, 32'h9);
        repeat (10) cyc(1, 0, 2, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 7);
        repeat (2) cyc(1, 0, 0, 0);

        // Auto-reload
        cyc(1, 1, 1, 3);
        cyc(1, 1, 0, 32'hB);
        repeat (16) cyc(1, 0, 2, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 2, 0);

        // Masked expiry, then clear via CTRL write
        cyc(1, 1, 1, 10);
        cyc(1, 1, 0, 32'h1);
        repeat (15) cyc(1, 0, 2, 0);
        cyc(1, 1, 0, 32'h8);
        repeat (3) cyc(1, 0, 2, 0);

        // Stop at COUNT=4
        cyc(1, 1, 0, 32'h1);
        n = 0;
        while (!(m_busy && m_age > 0 && m_age <= m_span() && m_cnt == 4)
               && n < 40) begin
            cyc(1, 0, 2, 0);
            n++;
        end
        if (n >= 40) check("wait_cnt4", 32'(n), 32'd0);
        cyc(1, 1, 0, 0);
        repeat (4) cyc(1, 0, 2, 0);

        // CTRL write collides with the expiry cycle
        cyc(1, 1, 1, 2);
        cyc(1, 1, 0, 32'h9);
        n = 0;
        while (!(m_busy && m_age == m_span() + 1) && n < 40) begin
            cyc(1, 0, 2, 0);
            n++;
        end
        if (n >= 40) check("wait_int", 32'(n), 32'd0);
        cyc(1, 1, 0, 32'h9);
        repeat (3) cyc(1, 0, 0, 0);
        repeat (6) cyc(1, 0, 2, 0);
        cyc(1, 1, 0, 0);

        // Random traffic
        repeat (400) begin
            ra  = 2'($urandom_range(0, 3));
            rs  = ($urandom_range(0, 7) != 0);
            rw  = ($urandom_range(0, 2) == 0);
            rwd = (ra == 2'd1) ? 32'($urandom_range(0, 6)) : 32'($urandom);
            cyc(rs, rw, ra, rwd);
        end
        cyc(1, 1, 0, 0);

        // Reset with IRQ pending after a one-shot expiry
        cyc(1, 1, 1, 3);
        cyc(1, 1, 0, 32'h9);
        repeat (8) cyc(1, 0, 0, 0);
        reset_check("rst_irq");

        // Reset while counting
        cyc(1, 1, 1, 20);
        cyc(1, 1, 0, 32'h9);
        repeat (6) cyc(1, 0, 2, 0);
        reset_check("rst_cnt");
        cyc(1, 0, 2, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);

        @(negedge Clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
